// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches, buffers responses in a
// small FIFO for the decoder, and flushes/restarts on a redirect.
module fetch_unit #(
  parameter int                 AddrSize  = 16,
  parameter int                 InstrSize = 32,
  parameter int                 Depth     = 4,
  parameter logic [AddrSize-1:0] ResetAddr = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 mem_req_o,
  output logic [AddrSize-1:0]  mem_addr_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [InstrSize-1:0] mem_rdata_i,
  output logic                 dec_valid_o,
  output logic [InstrSize-1:0] dec_instr_o,
  output logic [AddrSize-1:0]  dec_addr_o,
  input  logic                 dec_ready_i,
  input  logic                 redirect_i,
  input  logic [AddrSize-1:0]  redirect_addr_i
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  typedef enum logic [1:0] { StIdle, StWait, StDrop } state_e;

  state_e               state_q;
  logic [AddrSize-1:0]  pc_q, pc_d;
  logic [AddrSize-1:0]  out_addr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AddrSize-1:0]  fifo_addr_q  [Depth];
  logic [InstrSize-1:0] fifo_instr_q [Depth];
  logic                 grant, push, pop;

  // A request is only issued with a free slot, so a response push never overflows.
  assign mem_req_o  = !rst_i && (state_q == StIdle) && (count_q < DepthCnt) && !redirect_i;
  assign mem_addr_o = rst_i ? ResetAddr : pc_q;
  assign grant      = mem_req_o && mem_gnt_i;
  assign push       = (state_q == StWait) && mem_rvalid_i && !redirect_i;
  assign pop        = dec_valid_o && dec_ready_i;
  assign pc_d       = pc_q + AddrSize'(1);

  assign dec_valid_o = (count_q != '0);
  assign dec_instr_o = fifo_instr_q[rd_ptr_q];
  assign dec_addr_o  = fifo_addr_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Redirect outranks everything: it empties the FIFO and turns an in-flight request into one to discard.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pc_q       <= ResetAddr;
      out_addr_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < Depth; i++) begin
        fifo_addr_q[i]  <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else if (redirect_i) begin
      pc_q     <= redirect_addr_i;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      if (state_q != StIdle) begin
        state_q <= mem_rvalid_i ? StIdle : StDrop;
      end
    end else begin
      count_q <= count_d;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        fifo_addr_q[wr_ptr_q]  <= out_addr_q;
        fifo_instr_q[wr_ptr_q] <= mem_rdata_i;
        wr_ptr_q               <= wr_ptr_q + PtrW'(1);
      end
      case (state_q)
        StIdle: begin
          if (grant) begin
            out_addr_q <= pc_q;
            pc_q       <= pc_d;
            state_q    <= StWait;
          end
        end
        StWait, StDrop: begin
          if (mem_rvalid_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_unit;

  localparam int          AddrSize  = 16;
  localparam int          InstrSize = 32;
  localparam int          Depth     = 4;
  localparam logic [15:0] ResetAddr = 16'h0000;
  localparam int          NumVecs   = 12;

  logic        clk = 1'b0;
  logic        rst, memGnt, memRvalid, decReady, redirect;
  logic [31:0] memRdata;
  logic [15:0] redirectAddr;
  logic        memReq, decValid;
  logic [15:0] memAddr, decAddr;
  logic [31:0] decInstr;

  fetch_unit #(
    .AddrSize(AddrSize), .InstrSize(InstrSize), .Depth(Depth), .ResetAddr(ResetAddr)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_req_o(memReq), .mem_addr_o(memAddr), .mem_gnt_i(memGnt),
    .mem_rvalid_i(memRvalid), .mem_rdata_i(memRdata),
    .dec_valid_o(decValid), .dec_instr_o(decInstr), .dec_addr_o(decAddr),
    .dec_ready_i(decReady), .redirect_i(redirect), .redirect_addr_i(redirectAddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    logic [15:0] addr;
    logic        keep;
  } reqRec_t;

  typedef struct {
    logic        rst, gnt, rvalid, ready, redir;
    logic [31:0] rdata;
    logic [15:0] redirAddr;
    logic        expReq;
    logic [15:0] expAddr;
    logic        expValid, chkData;
    logic [15:0] expDecAddr;
    logic [31:0] expInstr;
  } vector_t;

  int          testsRun = 0;
  int          failCount = 0;
  entry_t      mFifo[$];
  reqRec_t     mOut[$];
  logic [15:0] mPc = ResetAddr;
  logic [15:0] memQ[$];
  logic [15:0] popAddrQ[$];
  logic [31:0] popInstrQ[$];
  logic        sampledGrant, sampledPop;
  logic [15:0] sampledAddr;
  vector_t     vecs [NumVecs];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                               input logic rdy, input logic rdr, input logic [15:0] ra);
    rst = r; memGnt = g; memRvalid = rv; memRdata = rd;
    decReady = rdy; redirect = rdr; redirectAddr = ra;
  endtask

  function automatic logic expReq();
    return !rst && (mOut.size() == 0) && (mFifo.size() < Depth) && !redirect;
  endfunction

  function automatic logic [15:0] expAddr();
    return rst ? ResetAddr : mPc;
  endfunction

  // Reference behaviour: one queue for buffered words, one for the single in-flight request.
  task automatic modelEdge();
    logic    grant, popNow;
    reqRec_t r;
    grant  = expReq() && memGnt;
    popNow = (mFifo.size() > 0) && decReady;
    if (rst) begin
      mFifo.delete(); mOut.delete(); mPc = ResetAddr;
    end else if (redirect) begin
      mFifo.delete(); mPc = redirectAddr;
      if (mOut.size() > 0) begin
        if (memRvalid) mOut.delete();
        else mOut[0].keep = 1'b0;
      end
    end else begin
      if (popNow) void'(mFifo.pop_front());
      if (memRvalid && mOut.size() > 0) begin
        r = mOut.pop_front();
        if (r.keep) mFifo.push_back('{addr: r.addr, instr: memRdata});
      end
      if (grant) begin
        mOut.push_back('{addr: mPc, keep: 1'b1});
        mPc = mPc + 16'h1;
      end
    end
  endtask

  task automatic sampleAndCheck();
    @(negedge clk);
    checkOutput("mem_req", memReq, expReq());
    checkOutput("mem_addr", memAddr, expAddr());
    if (!rst) begin
      checkOutput("dec_valid", decValid, mFifo.size() > 0);
      if (mFifo.size() > 0) begin
        checkOutput("dec_addr", decAddr, mFifo[0].addr);
        checkOutput("dec_instr", decInstr, mFifo[0].instr);
      end
    end
    sampledGrant = memReq && memGnt;
    sampledAddr  = memAddr;
    sampledPop   = !rst && decValid && decReady;
    if (sampledPop) begin
      popAddrQ.push_back(decAddr);
      popInstrQ.push_back(decInstr);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    modelEdge();
    if (memRvalid && memQ.size() > 0) void'(memQ.pop_front());
    if (sampledGrant) memQ.push_back(sampledAddr);
    #1;
  endtask

  // Memory answers every pending request in the next cycle with 0xA0000000 + address.
  task automatic stepAuto(input logic g, input logic rdy);
    logic        rv;
    logic [31:0] rd;
    rv = 1'b0;
    rd = 32'h0;
    if (memQ.size() > 0) begin
      rv = 1'b1;
      rd = 32'hA000_0000 + {16'h0, memQ[0]};
    end
    applyStimulus(1'b0, g, rv, rd, rdy, 1'b0, 16'h0);
    sampleAndCheck();
    advance();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, actual timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          grants;
    logic        seen;
    logic [15:0] seenAddr;
    logic        r, g, rv, rdy, rdr;
    logic [31:0] rd;
    logic [15:0] ra;

    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,16'h0, 1'b0,16'h0000,1'b0,1'b0,16'h0000,32'h0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,16'h0, 1'b0,16'h0000,1'b0,1'b0,16'h0000,32'h0};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,32'h0,16'h0, 1'b1,16'h0000,1'b0,1'b1,16'h0000,32'h0};
    vecs[3]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,32'hA0000000,16'h0, 1'b0,16'h0001,1'b0,1'b0,16'h0000,32'h0};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,32'h0,16'h0, 1'b1,16'h0001,1'b1,1'b1,16'h0000,32'hA0000000};
    vecs[5]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,32'hA0000001,16'h0, 1'b0,16'h0002,1'b0,1'b0,16'h0000,32'h0};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,32'h0,16'h0, 1'b1,16'h0002,1'b1,1'b1,16'h0001,32'hA0000001};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,32'hA0000002,16'h0, 1'b0,16'h0003,1'b0,1'b0,16'h0000,32'h0};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,32'h0,16'h0, 1'b1,16'h0003,1'b1,1'b1,16'h0002,32'hA0000002};
    vecs[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,32'hA0000003,16'h0, 1'b0,16'h0004,1'b0,1'b0,16'h0000,32'h0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,16'h0, 1'b1,16'h0004,1'b1,1'b1,16'h0003,32'hA0000003};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,16'h0, 1'b1,16'h0004,1'b0,1'b0,16'h0000,32'h0};

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    @(posedge clk);
    #1;

    // Reset and a streaming fetch of addresses 0..3.
    for (int i = 0; i < NumVecs; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata,
                    vecs[i].ready, vecs[i].redir, vecs[i].redirAddr);
      sampleAndCheck();
      checkOutput($sformatf("vec%0d_req", i), memReq, vecs[i].expReq);
      checkOutput($sformatf("vec%0d_addr", i), memAddr, vecs[i].expAddr);
      if (!vecs[i].rst) begin
        checkOutput($sformatf("vec%0d_valid", i), decValid, vecs[i].expValid);
        if (vecs[i].chkData) begin
          checkOutput($sformatf("vec%0d_dec_addr", i), decAddr, vecs[i].expDecAddr);
          checkOutput($sformatf("vec%0d_dec_instr", i), decInstr, vecs[i].expInstr);
        end
      end
      advance();
    end

    // Backpressure: exactly Depth grants, then drain in order and resume at addr 4.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    sampleAndCheck();
    advance();
    grants = 0;
    for (int i = 0; i < 20; i++) begin
      stepAuto(1'b1, 1'b0);
      if (sampledGrant) grants++;
    end
    checkOutput("bp_grants", grants, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    sampleAndCheck();
    checkOutput("bp_req_held", memReq, 1'b0);
    checkOutput("bp_full_valid", decValid, 1'b1);
    advance();
    popAddrQ.delete();
    popInstrQ.delete();
    for (int i = 0; i < 20 && popAddrQ.size() < 4; i++) stepAuto(1'b0, 1'b1);
    checkOutput("bp_drained", popAddrQ.size(), 4);
    for (int i = 0; i < popAddrQ.size(); i++) begin
      checkOutput($sformatf("bp_order%0d", i), popAddrQ[i], i);
      checkOutput($sformatf("bp_data%0d", i), popInstrQ[i], 32'hA000_0000 + i);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
    sampleAndCheck();
    checkOutput("bp_resume_req", memReq, 1'b1);
    checkOutput("bp_resume_addr", memAddr, 16'h0004);
    advance();
    for (int i = 0; i < 3; i++) stepAuto(1'b0, 1'b1);

    // Redirect while a request is in flight; its late response must be discarded.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
    sampleAndCheck();
    advance();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 16'h0040);
    sampleAndCheck();
    checkOutput("rw_req_on_redirect", memReq, 1'b0);
    advance();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 16'h0);
    sampleAndCheck();
    checkOutput("rw_req_while_drop", memReq, 1'b0);
    advance();
    popAddrQ.delete();
    popInstrQ.delete();
    seen = 1'b0;
    seenAddr = 16'h0;
    for (int i = 0; i < 12 && popAddrQ.size() < 1; i++) begin
      stepAuto(1'b1, 1'b1);
      if (sampledGrant && !seen) begin
        seen = 1'b1;
        seenAddr = sampledAddr;
      end
    end
    checkOutput("rw_next_req_addr", seenAddr, 16'h0040);
    checkOutput("rw_pops", popAddrQ.size(), 1);
    if (popAddrQ.size() > 0) begin
      checkOutput("rw_dec_addr", popAddrQ[0], 16'h0040);
      checkOutput("rw_dec_instr", popInstrQ[0], 32'hA000_0040);
    end

    // Redirect together with a pop while three entries are buffered.
    for (int i = 0; i < 20 && mFifo.size() < 3; i++) stepAuto((mFifo.size() + mOut.size()) < 3, 1'b0);
    checkOutput("rp_fill", mFifo.size(), 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 16'h0100);
    sampleAndCheck();
    checkOutput("rp_valid_at_redirect", decValid, 1'b1);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
    sampleAndCheck();
    checkOutput("rp_valid_after", decValid, 1'b0);
    checkOutput("rp_req_after", memReq, 1'b1);
    checkOutput("rp_addr_after", memAddr, 16'h0100);
    advance();
    popAddrQ.delete();
    popInstrQ.delete();
    for (int i = 0; i < 12 && popAddrQ.size() < 1; i++) stepAuto(1'b1, 1'b1);
    checkOutput("rp_pops", popAddrQ.size(), 1);
    if (popAddrQ.size() > 0) checkOutput("rp_dec_addr", popAddrQ[0], 16'h0100);

    // Address wrap from 0xFFFF to 0x0000.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 16'hFFFF);
    sampleAndCheck();
    advance();
    popAddrQ.delete();
    popInstrQ.delete();
    for (int i = 0; i < 20 && popAddrQ.size() < 2; i++) stepAuto(1'b1, 1'b1);
    checkOutput("wrap_pops", popAddrQ.size(), 2);
    if (popAddrQ.size() > 1) begin
      checkOutput("wrap_addr0", popAddrQ[0], 16'hFFFF);
      checkOutput("wrap_addr1", popAddrQ[1], 16'h0000);
    end

    // Reset while waiting; the late response must be ignored.
    for (int i = 0; i < 4; i++) stepAuto(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
    sampleAndCheck();
    checkOutput("rst_pre_grant", memReq, 1'b1);
    advance();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
    sampleAndCheck();
    checkOutput("rst_req_low", memReq, 1'b0);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 16'h0);
    sampleAndCheck();
    checkOutput("rst_first_req", memReq, 1'b1);
    checkOutput("rst_first_addr", memAddr, ResetAddr);
    checkOutput("rst_dec_instr", decInstr, 32'h0);
    checkOutput("rst_dec_addr", decAddr, 16'h0);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
    sampleAndCheck();
    checkOutput("rst_late_ignored", decValid, 1'b0);
    advance();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      g   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      rdr = ($urandom_range(0, 19) == 0);
      ra  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      rd  = $urandom;
      if (memQ.size() > 0) rv = ($urandom_range(0, 1) == 1);
      else rv = ($urandom_range(0, 9) == 0);
      applyStimulus(r, g, rv, rd, rdy, rdr, ra);
      sampleAndCheck();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the decoder. It generates sequential instruction addresses, fetches 32-bit instruction words from a latency-tolerant instruction memory, and buffers them in a small FIFO. It presents each word to the decoder with its address and a valid/ready handshake. A redirect input from the jump logic flushes the buffer and restarts fetching at a new address.

## Interface
- addr_size, 16, instruction address width (word addressed)
- instr_size, 32, instruction word width
- depth, 4, FIFO entries (power of two, ≥2)
- reset_addr, 0, first fetch address after reset

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_req  out  addr_size-independent 1  fetch request
- mem_addr  out  addr_size  address of requested word
- mem_gnt  in  1  request accepted when mem_req && mem_gnt
- mem_rvalid  in  1  response valid, in order, ≥1 cycle after grant
- mem_rdata  in  instr_size  response word
- dec_valid  out  1  FIFO head valid
- dec_instr  out  instr_size  FIFO head instruction
- dec_addr  out  addr_size  FIFO head address
- dec_ready  in  1  decoder consumes head when dec_valid && dec_ready
- redirect  in  1  flush and restart fetch
- redirect_addr  in  addr_size  new fetch address

## Operation
- Registers: fetch pointer pc, state, FIFO storage plus count (0..depth), outstanding-request address.
- States:
  - IDLE: no request outstanding.
  - WAIT: one request granted and awaiting a response.
  - DROP: one request outstanding whose response must be discarded.
- At most one outstanding request at any time.
- mem_req = (state==IDLE) && (count < depth) && !redirect. mem_addr = pc.
- Grant in IDLE: latch pc as the outstanding address, pc <= pc+1 mod 2^addr_size, go to WAIT.
- mem_rvalid in WAIT: push {outstanding address, mem_rdata}, go to IDLE.
- mem_rvalid in DROP: discard the response, go to IDLE.
- mem_rvalid in IDLE: ignored.
- Pop: dec_valid && dec_ready removes the head. Push and pop may occur in the same cycle; count is unchanged.
- A push is never blocked, because a request is issued only when count<depth and nothing else fills the FIFO.
- redirect (highest priority):
  - count <= 0, pc <= redirect_addr.
  - WAIT -> DROP; IDLE and DROP keep their state.
  - A pop in the same cycle is a completed transfer from the decoder's view; the FIFO is then empty.
  - A mem_rvalid in the same cycle is discarded; the state goes to IDLE if it was WAIT or DROP.
- Addresses wrap modulo 2^addr_size.
- Reset values:
  - mem_req 0 while rst is high; mem_addr = reset_addr.
  - dec_valid 0, dec_instr 0, dec_addr 0, count 0, state IDLE.
- Reset mid-operation: an outstanding request is forgotten. A response arriving after reset lands in IDLE and is ignored.

## Timing
- First request in the first cycle after rst falls, with mem_addr = reset_addr.
- Grant in cycle t, earliest response in t+1, dec_valid in t+2.
- Next request no earlier than the cycle after the response. Peak throughput is one instruction per 2 cycles with zero-latency memory.
- dec_valid, dec_instr and dec_addr are registered FIFO outputs; none is combinationally dependent on mem_rdata.
- After a redirect in cycle t, mem_req can assert at t+1 with mem_addr = redirect_addr. If the state is DROP, that request waits for the dropped response first.
- dec_valid is low in the cycle after a redirect unless a push lands that cycle.

## Test plan
- Stream: mem_gnt=1, response 1 cycle later with rdata = 0xA0000000+addr, dec_ready=1. The decoder must see addr 0,1,2,3 with matching data, one every 2 cycles.
- Backpressure: dec_ready=0, depth=4. Exactly 4 grants occur, then mem_req stays 0 and count=4. Raise dec_ready: the entries drain in order and fetch resumes at addr 4.
- Redirect while in WAIT: redirect to 0x0040, then the response 0xDEADBEEF arrives the next cycle. 0xDEADBEEF is never presented; the next mem_addr is 0x0040 and dec_addr 0x0040 follows.
- Redirect and pop in the same cycle with count=3: the popped entry counts as consumed, count becomes 0, and the next presented dec_addr equals redirect_addr.
- Wrap: redirect to 0xFFFF. Presented addresses are 0xFFFF then 0x0000.
- Reset mid-operation: assert rst for 1 cycle while in WAIT, then deliver a late mem_rvalid. It is ignored, dec_valid stays 0, and the first request addresses reset_addr.
